// File: rtl/serial_add_sub_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_sub_ctrl
//
// Bit-serial two's-complement adder/subtractor. A single full adder is
// time-shared across all WIDTH bits, one bit per clock, LSB first. A
// start/busy/done handshake sequences each operation: an operation occupies
// WIDTH+2 cycles from the start edge to the earliest next start edge.
//
// Subtraction is A + ~B + 1: B is inverted when it is loaded and the carry
// flop is preset to 1.
//
// Ports:
//   clk_i       clock, all state updates on the rising edge
//   rst_ni      synchronous active-low reset
//   start_i     request a new operation (sampled only in IDLE)
//   sub_i       0 = A+B, 1 = A-B (sampled with start_i)
//   a_i, b_i    operands (sampled with start_i)
//   busy_o      high while an operation is in progress (RUN or DONE)
//   done_o      one-cycle pulse: result/flags were just updated
//   result_o    last completed sum/difference, held until the next completion
//   carry_o     carry out of the MSB (for subtract: 1 = no borrow)
//   overflow_o  signed overflow of the last completed operation
// -----------------------------------------------------------------------------

module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_in,
    output logic sum_o,
    output logic carry_o
);
    assign sum_o   = a_i ^ b_i ^ c_in;
    assign carry_o = (a_i & b_i) | (a_i & c_in) | (b_i & c_in);
endmodule

module serial_add_sub_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             sub_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_o,
    output logic             overflow_o
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT    = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] PRE_MSB_BIT = CNT_W'(WIDTH - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opb_q, acc_q;
    logic             cy_q, cy_msb_in_q;
    logic [CNT_W-1:0] cnt_q;
    logic             fa_sum, fa_carry;

    // The only arithmetic element: adds bit 0 of both shifters with the
    // running carry.
    full_adder u_fa (
        .a_i     (opa_q[0]),
        .b_i     (opb_q[0]),
        .c_in    (cy_q),
        .sum_o   (fa_sum),
        .carry_o (fa_carry)
    );

    // ---------------------------------------------------------------- FSM
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // the pre-edge values of its neighbours, independent of block order.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // NOTE: next state is defaulted first so every path assigns it and no
    // latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = RUN;
            RUN:     if (cnt_q == LAST_BIT) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            opa_q       <= '0;
            opb_q       <= '0;
            acc_q       <= '0;
            cy_q        <= 1'b0;
            cy_msb_in_q <= 1'b0;
            cnt_q       <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            result_o    <= '0;
            carry_o     <= 1'b0;
            overflow_o  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        opa_q  <= a_i;
                        opb_q  <= b_i ^ {WIDTH{sub_i}};
                        cy_q   <= sub_i;
                        cnt_q  <= '0;
                        busy_o <= 1'b1;
                    end
                end
                RUN: begin
                    acc_q <= {fa_sum, acc_q[WIDTH-1:1]};
                    opa_q <= opa_q >> 1;
                    opb_q <= opb_q >> 1;
                    cy_q  <= fa_carry;
                    cnt_q <= cnt_q + 1'b1;
                    // Carry into the MSB; compared with the MSB carry-out
                    // it yields signed overflow.
                    if (cnt_q == PRE_MSB_BIT) cy_msb_in_q <= fa_carry;
                    if (cnt_q == LAST_BIT) begin
                        result_o   <= {fa_sum, acc_q[WIDTH-1:1]};
                        carry_o    <= fa_carry;
                        overflow_o <= fa_carry ^ cy_msb_in_q;
                        done_o     <= 1'b1;
                    end
                end
                DONE: begin
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                end
                default: begin
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_sub_ctrl.sv
// -----------------------------------------------------------------------------
// Directed bench for serial_add_sub_ctrl: a WIDTH=4 instance for the main
// function, exhaustive 4-bit sweep, ignored start and mid-op reset, and a
// WIDTH=8 instance for the overflow boundary.
// -----------------------------------------------------------------------------
module tb_serial_add_sub_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    always #5 clk = ~clk;

    // WIDTH=4 instance
    logic       start4, sub4;
    logic [3:0] a4, b4;
    logic       busy4, done4, carry4, ovf4;
    logic [3:0] res4;

    // WIDTH=8 instance
    logic       start8, sub8;
    logic [7:0] a8, b8;
    logic       busy8, done8, carry8, ovf8;
    logic [7:0] res8;

    serial_add_sub_ctrl #(.WIDTH(4)) u_dut4 (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start4),
        .sub_i      (sub4),
        .a_i        (a4),
        .b_i        (b4),
        .busy_o     (busy4),
        .done_o     (done4),
        .result_o   (res4),
        .carry_o    (carry4),
        .overflow_o (ovf4)
    );

    serial_add_sub_ctrl #(.WIDTH(8)) u_dut8 (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start8),
        .sub_i      (sub8),
        .a_i        (a8),
        .b_i        (b8),
        .busy_o     (busy8),
        .done_o     (done8),
        .result_o   (res8),
        .carry_o    (carry8),
        .overflow_o (ovf8)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Return 1 ns after the next rising edge: inputs change and outputs are
    // sampled there, away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a request, let it be sampled at the next edge (E0), then release.
    task automatic start_op4(input logic [3:0] a, input logic [3:0] b, input logic sub);
        a4 = a; b4 = b; sub4 = sub; start4 = 1'b1;
        tick();
        start4 = 1'b0;
    endtask

    // Called just after E0; returns the number of edges until done_o is seen.
    task automatic wait_done4(input string tag, output int n);
        n = 0;
        while (!done4 && n < 20) begin
            tick();
            n++;
        end
        if (!done4) check({tag, "_timeout"}, 32'(n), 32'd4);
    endtask

    task automatic check_op4(input string tag, input logic [3:0] r, input logic c, input logic v);
        check({tag, "_result"}, 32'(res4), 32'(r));
        check({tag, "_carry"}, 32'(carry4), 32'(c));
        check({tag, "_ovf"}, 32'(ovf4), 32'(v));
    endtask

    initial begin
        int n, busy_cnt, done_cnt, done_at;
        int sa, sb, sr;
        logic [3:0] exp_r;
        logic exp_c, exp_v;

        rst_n = 1'b0;
        start4 = 1'b0; sub4 = 1'b0; a4 = '0; b4 = '0;
        start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
        tick();
        tick();

        // Reset state
        check("rst_busy4", 32'(busy4), 32'd0);
        check("rst_done4", 32'(done4), 32'd0);
        check_op4("rst4", 4'd0, 1'b0, 1'b0);
        check("rst_res8", 32'(res8), 32'd0);
        rst_n = 1'b1;
        tick();

        // 1) 3+5: done exactly 4 edges after start, busy for exactly 5 cycles
        a4 = 4'd3; b4 = 4'd5; sub4 = 1'b0; start4 = 1'b1;
        busy_cnt = 0; done_cnt = 0; done_at = -1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 0) start4 = 1'b0;
            if (busy4) busy_cnt++;
            if (done4) begin
                done_cnt++;
                done_at = i;
                check_op4("add_3_5", 4'd8, 1'b0, 1'b1);
            end
        end
        check("add_3_5_done_edge", 32'(done_at), 32'd4);
        check("add_3_5_done_pulses", 32'(done_cnt), 32'd1);
        check("add_3_5_busy_cycles", 32'(busy_cnt), 32'd5);
        check("add_3_5_result_held", 32'(res4), 32'd8);

        // 2) subtract cases
        start_op4(4'd7, 4'd2, 1'b1);
        wait_done4("sub_7_2", n);
        check_op4("sub_7_2", 4'd5, 1'b1, 1'b0);
        tick();
        start_op4(4'd2, 4'd7, 1'b1);
        wait_done4("sub_2_7", n);
        check_op4("sub_2_7", 4'd11, 1'b0, 1'b0);
        tick();
        start_op4(4'd8, 4'd1, 1'b1);
        wait_done4("sub_8_1", n);
        check_op4("sub_8_1", 4'd7, 1'b1, 1'b1);
        tick();

        // 3) wrap, then exhaustive back-to-back sweep
        start_op4(4'd15, 4'd1, 1'b0);
        wait_done4("add_15_1", n);
        check_op4("add_15_1", 4'd0, 1'b1, 1'b0);
        tick();
        for (int k = 0; k < 512; k++) begin
            logic [3:0] ka, kb;
            logic       ks;
            ka = 4'(k >> 5); kb = 4'(k >> 1); ks = k[0];
            sa = (ka >= 8) ? int'(ka) - 16 : int'(ka);
            sb = (kb >= 8) ? int'(kb) - 16 : int'(kb);
            sr = ks ? sa - sb : sa + sb;
            exp_v = (sr > 7) || (sr < -8);
            exp_r = ks ? ka - kb : ka + kb;
            exp_c = ks ? (ka >= kb) : ((int'(ka) + int'(kb)) > 15);
            start_op4(ka, kb, ks);
            wait_done4("sweep", n);
            check("sweep_latency", 32'(n), 32'd4);
            check_op4("sweep", exp_r, exp_c, exp_v);
            tick();
            // Idle again after E5, so the next start lands on E6: 6 cycles/op.
            check("sweep_idle", 32'(busy4), 32'd0);
        end

        // 4) start held through RUN and DONE with new operands
        a4 = 4'd1; b4 = 4'd1; sub4 = 1'b0; start4 = 1'b1;
        tick();
        a4 = 4'd9; b4 = 4'd9;
        wait_done4("hold_first", n);
        check_op4("hold_first", 4'd2, 1'b0, 1'b0);
        tick();
        check("hold_idle_gap", 32'(busy4), 32'd0);
        tick();
        start4 = 1'b0; a4 = 4'd0; b4 = 4'd0; sub4 = 1'b1;
        check("hold_second_busy", 32'(busy4), 32'd1);
        wait_done4("hold_second", n);
        check("hold_second_latency", 32'(n), 32'd4);
        check_op4("hold_second", 4'd2, 1'b1, 1'b1);
        tick();

        // 5) reset at cnt=2 aborts the op and clears the held outputs
        start_op4(4'd5, 4'd6, 1'b0);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_busy", 32'(busy4), 32'd0);
        check("midrst_done", 32'(done4), 32'd0);
        check_op4("midrst", 4'd0, 1'b0, 1'b0);
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done4) done_cnt++;
        end
        check("midrst_no_done", 32'(done_cnt), 32'd0);
        start_op4(4'd4, 4'd4, 1'b0);
        wait_done4("after_rst", n);
        check_op4("after_rst", 4'd8, 1'b0, 1'b1);
        tick();

        // 6) WIDTH=8 overflow boundary
        a8 = 8'd100; b8 = 8'd27; sub8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        n = 0;
        while (!done8 && n < 30) begin tick(); n++; end
        check("w8_127_latency", 32'(n), 32'd8);
        check("w8_127_result", 32'(res8), 32'd127);
        check("w8_127_ovf", 32'(ovf8), 32'd0);
        check("w8_127_carry", 32'(carry8), 32'd0);
        tick();
        a8 = 8'd100; b8 = 8'd28; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        n = 0;
        while (!done8 && n < 30) begin tick(); n++; end
        check("w8_128_latency", 32'(n), 32'd8);
        check("w8_128_result", 32'(res8), 32'd128);
        check("w8_128_ovf", 32'(ovf8), 32'd1);
        check("w8_128_carry", 32'(carry8), 32'd0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
